// File: rtl/adder_seq_pkg.sv
// Shared sizing and FSM state type for the sequential slice-by-slice adder.
package adder_seq_pkg;
    localparam int WORD_W    = 8;
    localparam int NUM_WORDS = 4;
    localparam int OP_W      = WORD_W * NUM_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/fulladderNbit.sv
// Combinational N-bit ripple adder slice with carry in/out.
module fulladderNbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    end
endmodule

// File: rtl/adder_seq_ctrl.sv
// Adds two OP_W operands one WORD_W slice per clock through a single shared adder; result valid NUM_WORDS edges after accept.
// Holds the result in DONE until out_ready; accepts a new request only from IDLE.
module adder_seq_ctrl #(
    parameter int   WORD_W    = adder_seq_pkg::WORD_W,
    parameter int   NUM_WORDS = adder_seq_pkg::NUM_WORDS,
    localparam int  OP_W      = WORD_W * NUM_WORDS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    input  logic            in_cin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_sum,
    output logic            out_cout
);
    import adder_seq_pkg::*;

    localparam int               IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic [OP_W-1:0]   sum_q, sum_d;
    logic              cout_q, cout_d;

    logic [WORD_W-1:0] a_slice, b_slice, fa_sum;
    logic              fa_cout;

    always_comb begin
        a_slice = a_q[int'(idx_q) * WORD_W +: WORD_W];
        b_slice = b_q[int'(idx_q) * WORD_W +: WORD_W];
    end

    fulladderNbit #(
        .N (WORD_W)
    ) u_fa (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                sum_d[int'(idx_q) * WORD_W +: WORD_W] = fa_sum;
                carry_d = fa_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = fa_cout;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // No accept on the consume edge: IDLE is only reached after it.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench: expected sums queued at accept, compared when a result is consumed.
module tb_adder_seq_ctrl;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   acc_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t ref_add(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [32:0] full;
        exp_t e;
        full   = {1'b0, a} + {1'b0, b} + {32'd0, c};
        e.sum  = full[31:0];
        e.cout = full[32];
        return e;
    endfunction

    // Consume-side monitor: a result is taken on the edge following this sample.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_sum", {32'd0, out_sum}, {32'd0, e.sum});
                check("out_cout", {63'd0, out_cout}, {63'd0, e.cout});
            end
        end
    end

    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic c, input bit keep);
        int t;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 50) check("accept_timeout", 64'd0, 64'd1);
        exp_q.push_back(ref_add(a, b, c));
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check(tag, 64'(cyc - acc_cyc), 64'd4);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   t;
        int   prev;
        exp_t e;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_sum", {32'd0, out_sum}, 64'd0);
        check("rst_out_cout", {63'd0, out_cout}, 64'd0);
        reset = 1'b0;

        // Carry-in case; accept must land on the very first edge after reset.
        accept(32'h12345678, 32'h11111111, 1'b1, 1'b0);
        check("first_accept_edge", 64'(acc_cyc), 64'(cyc));
        wait_valid("lat_cin");
        drain();

        // Full carry ripple under backpressure.
        out_ready = 1'b0;
        accept(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        wait_valid("lat_ripple");
        in_valid = 1'b1;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h01010101;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_sum", {32'd0, out_sum}, 64'd0);
            check("hold_cout", {63'd0, out_cout}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("consume_out_valid", {63'd0, out_valid}, 64'd0);
        check("consume_in_ready", {63'd0, in_ready}, 64'd1);
        drain();

        // Busy ignore: a request raised during ADD waits for IDLE.
        accept(32'h01020304, 32'h10203040, 1'b0, 1'b1);
        prev   = acc_cyc;
        in_a   = 32'hAAAAAAAA;
        in_b   = 32'hAAAAAAAA;
        in_cin = 1'b0;
        wait_valid("lat_busy");
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        exp_q.push_back(ref_add(32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0));
        acc_cyc = cyc + 1;
        check("busy_accept_gap", 64'(acc_cyc - prev), 64'd6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid("lat_busy2");
        drain();

        // Reset after slice 2 has been written.
        accept(32'h87654321, 32'h0F0F0F0F, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        reset = 1'b0;
        accept(32'h00000005, 32'h00000003, 1'b0, 1'b0);
        wait_valid("lat_after_rst");
        drain();

        // Back-to-back random stream, one result every 6 edges.
        in_valid = 1'b1;
        prev     = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic        rc;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            t = 0;
            while (!in_ready && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            in_a   = ra;
            in_b   = rb;
            in_cin = rc;
            exp_q.push_back(ref_add(ra, rb, rc));
            acc_cyc = cyc + 1;
            if (i > 0) check("b2b_gap", 64'(acc_cyc - prev), 64'd6);
            prev = acc_cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
